// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response, decode-side instruction
// and commit feedback. The master is the fetch unit; the slave is its environment.
interface ifu_fetch_if #(
   parameter int XLEN = 32
);
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_data;
   logic            inst_valid;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            commit_valid;
   logic [XLEN-1:0] commit_pc;
   logic            fetch_misalign;
   logic [31:0]     fetch_count;

   modport master (
      output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
             fetch_misalign, fetch_count,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, commit_valid, commit_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
             fetch_misalign, fetch_count,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, commit_valid, commit_pc
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and holds it
// for decode until the core commits the next PC.
module ifu_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic      clk,
   input  logic      rst,
   ifu_fetch_if.master fetch_if
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, ERR} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     fetch_count_q, fetch_count_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         inst_q        <= '0;
         inst_pc_q     <= '0;
         misalign_q    <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         inst_pc_q     <= inst_pc_d;
         misalign_q    <= misalign_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      inst_pc_d     = inst_pc_q;
      misalign_d    = misalign_q;
      fetch_count_d = fetch_count_q;
      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (fetch_if.mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (fetch_if.mem_rsp_valid) begin
               inst_d        = fetch_if.mem_rsp_data;
               inst_pc_d     = pc_q;
               fetch_count_d = fetch_count_q + 32'd1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            if (fetch_if.commit_valid) begin
               // A misaligned target is a dead end: keep the old PC and stop fetching.
               if (fetch_if.commit_pc[1:0] == 2'b00) begin
                  pc_d    = fetch_if.commit_pc;
                  state_d = REQ;
               end else begin
                  misalign_d = 1'b1;
                  state_d    = ERR;
               end
            end
         end
         ERR:     state_d = ERR;
         default: state_d = BOOT;
      endcase
   end

   assign fetch_if.mem_req_valid  = (state_q == REQ);
   assign fetch_if.mem_req_addr   = pc_q;
   assign fetch_if.inst_valid     = (state_q == HOLD);
   assign fetch_if.inst           = inst_q;
   assign fetch_if.inst_pc        = inst_pc_q;
   assign fetch_if.fetch_misalign = misalign_q;
   assign fetch_if.fetch_count    = fetch_count_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit for the npc core. It sits directly upstream of instruction decode and the immediate decoder. It owns the PC, issues a valid/ready read request to instruction memory, and captures the 32-bit instruction word. It holds that word and its PC stable on `inst` until the execute/writeback side commits the next PC.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
XLEN, 32, address and instruction width; only 32 is supported.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
mem_req_valid  out  1  fetch request valid.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  XLEN  fetch address; always equals pc.
mem_rsp_valid  in  1  read data valid.
mem_rsp_data  in  XLEN  instruction word.
inst_valid  out  1  inst and inst_pc hold a fetched instruction.
inst  out  XLEN  instruction word to decode (the `cmd` input of decode).
inst_pc  out  XLEN  PC of inst.
commit_valid  in  1  current instruction has retired; commit_pc is valid.
commit_pc  in  XLEN  next PC (pc+4, branch or jump target).
fetch_misalign  out  1  sticky flag: a misaligned commit_pc was received.
fetch_count  out  32  number of instructions delivered; wraps.

Behaviour:
- Reset is asynchronous and active-high. While rst=1 and during the first cycle after rst deasserts:
  - state=BOOT, pc=RESET_PC.
  - mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
  - fetch_misalign=0, fetch_count=0.
- State machine with states BOOT, REQ, WAIT, HOLD, ERR:
  - BOOT -> REQ unconditionally after one cycle.
  - REQ: mem_req_valid=1 and mem_req_addr=pc. If mem_req_ready=1, the request is accepted and the state moves to WAIT. The address stays stable until accepted.
  - WAIT: mem_req_valid=0. On mem_rsp_valid=1, latch inst<=mem_rsp_data and inst_pc<=pc, set inst_valid<=1, increment fetch_count, and move to HOLD. Zero-wait memory (req_ready in cycle N, rsp_valid in cycle N+1) gives inst_valid in cycle N+2.
  - HOLD: inst_valid=1 with inst and inst_pc unchanged. On commit_valid=1:
    - If commit_pc[1:0]==0: pc<=commit_pc, inst_valid<=0, next state REQ, so the new request issues the following cycle.
    - Otherwise: set fetch_misalign<=1, inst_valid<=0, pc unchanged, next state ERR.
  - ERR: terminal until reset. mem_req_valid=0, inst_valid=0, fetch_misalign stays 1.
- commit_valid in any state other than HOLD is ignored; pc is unchanged.
- mem_rsp_valid in any state other than WAIT is ignored. This includes a late response that arrives after a reset aborted a WAIT.
- Only one request is outstanding at any time.
- The commit in HOLD completes in a single cycle, since the downstream single-cycle core always retires.
- fetch_count is 32-bit and wraps from 32'hFFFF_FFFF to 0.
- pc arithmetic is done by the commit source; this block performs no addition.
- Reset mid-WAIT or mid-HOLD immediately clears all state to reset values; the next fetch is from RESET_PC.
- mem_req_valid and inst_valid are decoded from registered state only; there is no combinational path from any input to any output.

Test Plan:
1. Reset release, mem_req_ready=1, rsp one cycle later with data 32'h00000413 -> request at addr 32'h80000000 in cycle 1 after BOOT. inst_valid=1 with inst=32'h00000413, inst_pc=32'h80000000, fetch_count=1.
2. In HOLD, commit_valid=1 with commit_pc=32'h80000004 -> inst_valid drops next cycle. mem_req_addr=32'h80000004 with mem_req_valid=1 the cycle after.
3. Back-pressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid stays 1 and mem_req_addr stays constant. The transition to WAIT occurs only on the ready cycle.
4. Misaligned commit: commit_pc=32'h80000102 in HOLD -> fetch_misalign=1, state ERR, no further mem_req_valid until rst. A subsequent rst clears the flag and refetches 32'h80000000.
5. Spurious events: mem_rsp_valid pulsed in REQ and in HOLD, commit_valid pulsed in WAIT -> inst, inst_pc, pc and fetch_count are unchanged.
6. Async reset asserted mid-WAIT, then the response arrives after release during BOOT/REQ -> response ignored, inst_valid=0, refetch from 32'h80000000. Separately, preload fetch_count=32'hFFFFFFFF via a long run or force, then deliver one instruction -> fetch_count wraps to 0.
